addsub_nibble_seq: RTL
======================

// Module: addsub_nibble_seq
// PURPOSE
//  Multi-word add/subtract controller. Sequences one 4-bit add/sub slice over NIBBLES operand nibbles,
//  LSB first. Holds the carry/borrow in a register between nibbles.
//  Provides wide A+B / A-B on a single 4-bit adder at NIBBLES clocks per operation.
//  Sits between a requesting FSM/bus and the result consumer; Start/Ready/Done handshake.
// PARAMETERS
//  NIBBLES  4  number of 4-bit slices; operand width W = 4*NIBBLES (legal: 1..16)
// PORTS
//  clk      in   1   single clock, all state updates on rising edge
//  rst      in   1   synchronous, active-high reset
//  Start    in   1   request; sampled only when Ready=1
//  A        in   W   minuend / addend, latched on accepted Start
//  B        in   W   subtrahend / addend, latched on accepted Start
//  Mode     in   1   0 = A+B, 1 = A-B (two's complement); latched on accepted Start
//  Ready    out  1   1 when in IDLE and able to accept Start
//  Done     out  1   single-cycle pulse: S_D, C_B_out, Ovf valid and new
//  S_D      out  W   sum/difference, held until next completion
//  C_B_out  out  1   carry out of MSB (subtract: 1 = no borrow, 0 = borrow)
//  Ovf      out  1   signed overflow = carry into MSB bit XOR carry out of MSB bit
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, idx=0, carry reg=0, S_D=0, C_B_out=0, Ovf=0, Done=0.
//    Ready=1 in the cycle after the reset edge. Reset overrides Start and any in-flight operation.
//  States: IDLE -> RUN -> DONE -> IDLE. Ready = (state==IDLE), combinational from state.
//  IDLE: edge k with Start=1 latches A, B and Mode, then sets idx=0, carry=Mode, state=RUN.
//    Start=0 stays in IDLE.
//  RUN, one nibble per edge (edges k+1 .. k+NIBBLES):
//    n = idx; t = A[4n+3:4n] + (B[4n+3:4n] ^ {4{Mode}}) + carry (5-bit result).
//    Result nibble n <= t[3:0]; carry <= t[4]; idx <= idx+1.
//    Partial results go to an internal working reg. S_D does NOT change during RUN.
//  Last nibble (idx==NIBBLES-1):
//    S_D <= full working result; C_B_out <= t[4]; Ovf <= c3 ^ t[4], where c3 = carry into bit 3 of that nibble.
//    Done <= 1; state <= DONE.
//  DONE: lasts one cycle. Done=1 here only. Next edge: Done <= 0, state <= IDLE.
//  Latency: Start sampled at edge k -> Done high in cycle after edge k+NIBBLES.
//    Earliest next accept is edge k+NIBBLES+2, i.e. a throughput of NIBBLES+2 cycles per op.
//  Start while Ready=0 (RUN/DONE) is ignored, not queued. A/B/Mode changes during RUN have no effect.
//  Arithmetic is modulo 2^W. NIBBLES=1 gives RUN length 1 and the same protocol.
//  Outputs S_D/C_B_out/Ovf keep the last result through IDLE and the next RUN; they are cleared only by reset.
//  Reset in RUN: operation discarded, no Done pulse, outputs zeroed.
// TESTING (NIBBLES=4 unless stated)
//  1. 0x1234 + 0x0FFF, Mode=0 -> S_D=0x2233, C_B_out=0, Ovf=0; Done exactly 4 edges after accept edge.
//  2. 0x0000 - 0x0001, Mode=1 -> S_D=0xFFFF, C_B_out=0 (borrow), Ovf=0.
//  3. 0x7FFF + 0x0001 -> S_D=0x8000, Ovf=1, C_B_out=0; 0xFFFF + 0x0001 -> S_D=0x0000, C_B_out=1, Ovf=0.
//  4. Hold Start=1 continuously: ops accepted every 6 cycles. Second Start pulse during RUN ignored (one Done only).
//  5. rst at 2nd RUN edge -> no Done, S_D=0, Ready=1 next cycle; then 0x8000-0x0001 -> 0x7FFF, Ovf=1, C_B_out=1.
//  6. NIBBLES=1: 0x9 - 0x3 -> S_D=0x6, C_B_out=1, Ovf=1; Done 1 edge after accept.

Source files
------------

// File: rtl/addsub_nibble_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_nibble_seq_if
//  Brief    : Start/Ready/Done request bus for the nibble-serial add/sub unit.
//             The master side issues operands, the slave side returns the result.
//  Revision : 1.0 - initial release
// ============================================================================
interface addsub_nibble_seq_if #(
  parameter int NIBBLES = 4
) ();
  logic                   Start;
  logic [4*NIBBLES-1:0]   A;
  logic [4*NIBBLES-1:0]   B;
  logic                   Mode;
  logic                   Ready;
  logic                   Done;
  logic [4*NIBBLES-1:0]   S_D;
  logic                   C_B_out;
  logic                   Ovf;

  modport master (
    output Start, A, B, Mode,
    input  Ready, Done, S_D, C_B_out, Ovf
  );

  modport slave (
    input  Start, A, B, Mode,
    output Ready, Done, S_D, C_B_out, Ovf
  );
endinterface
`default_nettype wire

// File: rtl/addsub_nibble_seq.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_nibble_seq
//  Brief    : Wide A+B / A-B computed on a single 4-bit slice, one nibble per
//             clock, LSB first, with the carry/borrow held between nibbles.
//  Revision : 1.0 - initial release
// ============================================================================
module addsub_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  addsub_nibble_seq_if.slave bus
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] c_LAST = IW'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_mode;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_work;
  logic [W-1:0]  r_sd;
  logic          r_cb;
  logic          r_ovf;

  logic          w_last;
  logic [IW+1:0] w_sh;
  logic [W-1:0]  w_a_shr;
  logic [W-1:0]  w_b_shr;
  logic [3:0]    w_a_nib;
  logic [3:0]    w_b_nib;
  logic [4:0]    w_t;
  logic [3:0]    w_low;
  logic          w_c3;
  logic [W-1:0]  w_work_nxt;

  // Slice datapath: select the current nibble, invert B for subtract, add.
  always_comb begin
    w_last     = (r_idx == c_LAST);
    w_sh       = {r_idx, 2'b00};
    w_a_shr    = r_a >> w_sh;
    w_b_shr    = r_b >> w_sh;
    w_a_nib    = w_a_shr[3:0];
    w_b_nib    = w_b_shr[3:0] ^ {4{r_mode}};
    w_t        = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
    // Carry into bit 3 is the carry out of the low three bits.
    w_low      = {1'b0, w_a_nib[2:0]} + {1'b0, w_b_nib[2:0]} + {3'b000, r_carry};
    w_c3       = w_low[3];
    w_work_nxt = r_work | (W'(w_t[3:0]) << w_sh);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: accept in IDLE, step through nibbles, single DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.Start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.Ready = (r_state == S_IDLE);
    bus.Done  = (r_state == S_DONE);
  end

  // Operand capture, per-nibble accumulation and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_work  <= '0;
      r_sd    <= '0;
      r_cb    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_mode  <= bus.Mode;
            r_idx   <= '0;
            r_carry <= bus.Mode;
            r_work  <= '0;
          end
        end
        S_RUN: begin
          r_work  <= w_work_nxt;
          r_carry <= w_t[4];
          if (w_last) begin
            r_idx <= '0;
            r_sd  <= w_work_nxt;
            r_cb  <= w_t[4];
            r_ovf <= w_c3 ^ w_t[4];
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result outputs hold the last completed operation.
  always_comb begin
    bus.S_D     = r_sd;
    bus.C_B_out = r_cb;
    bus.Ovf     = r_ovf;
  end

endmodule
`default_nettype wire
